// File: rtl/sid_write_queue.sv
`timescale 1ns/1ps
// sid_write_queue: buffers decoded SID register writes from the USB decoder
// and releases at most one of them per 1 MHz SID tick (clkEn).
//
// Optional feature macro: SID_WRITE_DELAY_EN
//   When defined, a queued write to address 5'h1F is a delay token. It is
//   consumed without a strobe and holds off the next pop for N extra ticks,
//   where N is the token's data byte.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   clkEn           1 MHz SID clock enable, one clk cycle wide
//   iAddr/iData/iWE decoded register write (push)
//   oAddr/oData/oWE write presented to the SID, oWE is a one-cycle strobe
//   oLevel          FIFO occupancy (registered)
//   oFull           occupancy equals depth (registered)
//   oOverflow       sticky, set when a push is dropped
module sid_write_queue #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkEn,
  input  logic [4:0]            iAddr,
  input  logic [7:0]            iData,
  input  logic                  iWE,
  output logic [4:0]            oAddr,
  output logic [7:0]            oData,
  output logic                  oWE,
  output logic [DEPTH_LOG2:0]   oLevel,
  output logic                  oFull,
  output logic                  oOverflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned EW    = 13;

  localparam logic [LW-1:0]         DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Entry storage, {addr, data}
  logic [EW-1:0]         mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q,  level_d;
  logic                  full_q,   full_d;
  logic                  ovf_q,    ovf_d;
  logic [4:0]            addr_q,   addr_d;
  logic [7:0]            data_q,   data_d;
  logic                  we_q,     we_d;

  logic [EW-1:0]         head_c;
  logic                  delay_idle_c;
  logic                  pop_c;
  logic                  push_c;

`ifdef SID_WRITE_DELAY_EN
  localparam logic [4:0] DELAY_ADDR = 5'h1F;
  logic [7:0]            delay_q, delay_d;
  assign delay_idle_c = (delay_q == 8'd0);
`else
  assign delay_idle_c = 1'b1;
`endif

  assign head_c = mem_q[rd_ptr_q];

  // Pop uses pre-cycle occupancy, so a push into an empty queue cannot pop
  assign pop_c  = clkEn && (level_q != '0) && delay_idle_c;
  // A full queue still accepts a push when a slot frees in the same cycle
  assign push_c = iWE && ((level_q != DEPTH_L) || pop_c);

  // Next-state logic for pointers, occupancy, flags and output latch
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
`ifdef SID_WRITE_DELAY_EN
    delay_d  = delay_q;
`endif

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (iWE && !push_c) begin
      ovf_d = 1'b1;
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef SID_WRITE_DELAY_EN
      if (head_c[12:8] == DELAY_ADDR) begin
        // Token occupies this tick's slot; next pop is data+1 ticks away
        delay_d = head_c[7:0];
      end else begin
        addr_d = head_c[12:8];
        data_d = head_c[7:0];
        we_d   = 1'b1;
      end
`else
      addr_d = head_c[12:8];
      data_d = head_c[7:0];
      we_d   = 1'b1;
`endif
    end

`ifdef SID_WRITE_DELAY_EN
    // WAIT: burn one tick per clkEn until the counter is back to zero
    if (clkEn && !delay_idle_c) begin
      delay_d = delay_q - 8'd1;
    end
`endif

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    full_d = (level_d == DEPTH_L);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 8'd0;
      we_q     <= 1'b0;
`ifdef SID_WRITE_DELAY_EN
      delay_q  <= 8'd0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
`ifdef SID_WRITE_DELAY_EN
      delay_q  <= delay_d;
`endif
    end
  end

  // Storage array; contents are don't-care until written, pointers gate reads
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {iAddr, iData};
    end
  end

  assign oAddr     = addr_q;
  assign oData     = data_q;
  assign oWE       = we_q;
  assign oLevel    = level_q;
  assign oFull     = full_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_sid_write_queue.sv
`timescale 1ns/1ps
// Scoreboard bench for sid_write_queue: the stimulus side queues expected SID
// writes, a negedge monitor pops and compares them on every oWE strobe.
module tb_sid_write_queue;

  localparam int unsigned DL2 = 6;

  logic           clk;
  logic           rst;
  logic           clkEn;
  logic [4:0]     iAddr;
  logic [7:0]     iData;
  logic           iWE;
  logic [4:0]     oAddr;
  logic [7:0]     oData;
  logic           oWE;
  logic [DL2:0]   oLevel;
  logic           oFull;
  logic           oOverflow;

  sid_write_queue #(.DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .iAddr     (iAddr),
    .iData     (iData),
    .iWE       (iWE),
    .oAddr     (oAddr),
    .oData     (oData),
    .oWE       (oWE),
    .oLevel    (oLevel),
    .oFull     (oFull),
    .oOverflow (oOverflow)
  );

  typedef struct {
    logic [4:0]  a;
    logic [7:0]  d;
    int unsigned gap;   // required clk cycles since previous strobe, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   ph      = 0;
  bit   tick_run = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 MHz tick model: one clkEn cycle every 24 clk cycles while running
  initial begin
    clkEn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_run) ph = (ph == 23) ? 0 : ph + 1;
      else          ph = 0;
      clkEn = tick_run && (ph == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [7:0] d, input int unsigned gap);
    exp_t e;
    e.a = a; e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Drive one push for exactly one clock edge
  task automatic push1(input logic [4:0] a, input logic [7:0] d);
    iAddr = a;
    iData = d;
    iWE   = 1'b1;
    @(posedge clk);
    #1;
    iWE   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d strobes still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_clken(input int budget);
    int k = 0;
    while (clkEn !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (clkEn !== 1'b1) begin
      n_total++;
      $display("FAIL wait_clkEn: got no tick within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_phase(input int target, input int budget);
    int k = 0;
    while (ph != target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (ph != target) begin
      n_total++;
      $display("FAIL wait_phase: got phase %0d, expected %0d", ph, target);
    end
  endtask

  // Monitor: every strobe must match the scoreboard head and follow a tick
  int   cyc      = 0;
  int   last_cyc = 0;
  logic prev_en  = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (oWE === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h, expected no strobe (t=%0t)",
                   oAddr, oData, $time);
        end else begin
          e = exp_q.pop_front();
          check("strobe_addr", 32'(oAddr), 32'(e.a));
          check("strobe_data", 32'(oData), 32'(e.d));
          check("strobe_after_clkEn", 32'(prev_en), 32'd1);
          if (e.gap != 0) check("strobe_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_cyc = cyc;
      end
      prev_en = clkEn;
    end
  end

  initial begin
    rst   = 1'b1;
    iWE   = 1'b0;
    iAddr = 5'd0;
    iData = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_oWE",       32'(oWE),       32'd0);
    check("rst_oAddr",     32'(oAddr),     32'd0);
    check("rst_oData",     32'(oData),     32'd0);
    check("rst_oLevel",    32'(oLevel),    32'd0);
    check("rst_oFull",     32'(oFull),     32'd0);
    check("rst_oOverflow", 32'(oOverflow), 32'd0);
    rst      = 1'b0;
    tick_run = 1'b1;

    // Single write shortly before a tick
    wait_phase(20, 60);
    expect_wr(5'h18, 8'h0F, 0);
    push1(5'h18, 8'h0F);
    @(negedge clk);
    check("single_level_1", 32'(oLevel), 32'd1);
    drain(60);
    check("single_level_0", 32'(oLevel), 32'd0);

    // Burst of 10 consecutive pushes, released 24 cycles apart
    tick_run = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      expect_wr(5'(i), 8'(8'hA0 + i), (i == 0) ? 0 : 24);
      push1(5'(i), 8'(8'hA0 + i));
    end
    @(negedge clk);
    check("burst_peak_level", 32'(oLevel), 32'd10);
    check("burst_full",       32'(oFull),  32'd0);
    tick_run = 1'b1;
    drain(10 * 24 + 60);
    check("burst_overflow", 32'(oOverflow), 32'd0);
    check("burst_level_0",  32'(oLevel),    32'd0);

    // Fill to 64, drop 65 and 66
    tick_run = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 64; i++) begin
      expect_wr(5'(i), 8'(i), (i == 1) ? 0 : 24);
      push1(5'(i), 8'(i));
    end
    @(negedge clk);
    check("fill_full",      32'(oFull),     32'd1);
    check("fill_level",     32'(oLevel),    32'd64);
    check("fill_overflow0", 32'(oOverflow), 32'd0);
    push1(5'd1, 8'd65);
    push1(5'd2, 8'd66);
    @(negedge clk);
    check("drop_overflow", 32'(oOverflow), 32'd1);
    check("drop_level",    32'(oLevel),    32'd64);
    check("drop_full",     32'(oFull),     32'd1);

    // Push in the same cycle as the first pop while full
    tick_run = 1'b1;
    wait_clken(40);
    expect_wr(5'h15, 8'hC3, 24);
    push1(5'h15, 8'hC3);
    @(negedge clk);
    check("pushpop_level", 32'(oLevel), 32'd64);
    check("pushpop_full",  32'(oFull),  32'd1);
    drain(65 * 24 + 100);
    check("full_drain_level", 32'(oLevel), 32'd0);

    // Delay token between two writes
    tick_run = 1'b0;
    @(negedge clk);
    expect_wr(5'h03, 8'h55, 0);
`ifdef SID_WRITE_DELAY_EN
    expect_wr(5'h04, 8'h66, 120);
`else
    expect_wr(5'h1F, 8'h03, 24);
    expect_wr(5'h04, 8'h66, 24);
`endif
    push1(5'h03, 8'h55);
    push1(5'h1F, 8'h03);
    push1(5'h04, 8'h66);
    tick_run = 1'b1;
    drain(300);
    check("token_level_0", 32'(oLevel), 32'd0);

    // Asynchronous reset with entries queued and a delay pending
    tick_run = 1'b0;
    @(negedge clk);
`ifndef SID_WRITE_DELAY_EN
    expect_wr(5'h1F, 8'h07, 0);
`endif
    push1(5'h1F, 8'h07);
    for (int i = 0; i < 5; i++) push1(5'(8 + i), 8'(8'h70 + i));
    tick_run = 1'b1;
    wait_clken(40);
    @(negedge clk);
    check("pre_rst_level", 32'(oLevel), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_oWE",       32'(oWE),       32'd0);
    check("midrst_oAddr",     32'(oAddr),     32'd0);
    check("midrst_oData",     32'(oData),     32'd0);
    check("midrst_oLevel",    32'(oLevel),    32'd0);
    check("midrst_oFull",     32'(oFull),     32'd0);
    check("midrst_oOverflow", 32'(oOverflow), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("post_rst_level", 32'(oLevel), 32'd0);
    expect_wr(5'h02, 8'h5A, 0);
    push1(5'h02, 8'h5A);
    drain(60);
    check("post_rst_final_level", 32'(oLevel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
